// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C register-access master
// between several clients, with per-transaction completion status and timeout abort.
module i2c_txn_arbiter #(
    parameter int NumRequesters = 2,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NumRequesters-1:0]          req_valid,
    input  logic [NumRequesters-1:0]          req_rw,
    input  logic [7*NumRequesters-1:0]        req_dev,
    input  logic [8*NumRequesters-1:0]        req_reg,
    input  logic [8*NumRequesters-1:0]        req_wdata,
    output logic [NumRequesters-1:0]          req_done,
    output logic [7:0]                        rsp_rdata,
    output logic                              rsp_nack,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [$clog2(NumRequesters)-1:0]  grant,
    output logic                              txn_valid,
    input  logic                              txn_ready,
    output logic                              txn_rw,
    output logic [6:0]                        txn_dev,
    output logic [7:0]                        txn_reg,
    output logic [7:0]                        txn_wdata,
    input  logic                              txn_done,
    input  logic [7:0]                        txn_rdata,
    input  logic                              txn_nack,
    output logic                              txn_abort
);

    localparam int GW = $clog2(NumRequesters);
    localparam int CW = $clog2(TimeoutCycles);
    // Abort fires on the edge where the counter would reach TimeoutCycles-1.
    localparam logic [CW-1:0] CntLast = CW'(TimeoutCycles - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_r, state_nx;
    logic [GW-1:0]           rr_r, rr_nx, grant_nx, pick, cand;
    logic [CW-1:0]           cnt_r, cnt_nx;
    logic                    found, hit;
    int                      scan_idx;
    logic                    sel_rw;
    logic [6:0]              sel_dev;
    logic [7:0]              sel_reg, sel_wdata;
    logic [NumRequesters-1:0] req_done_nx;
    logic [7:0]              rsp_rdata_nx;
    logic                    rsp_nack_nx, rsp_timeout_nx, busy_nx;
    logic                    txn_valid_nx, txn_rw_nx, txn_abort_nx;
    logic [6:0]              txn_dev_nx;
    logic [7:0]              txn_reg_nx, txn_wdata_nx;

    // Round-robin scan starting just after the last served client.
    always_comb begin
        found    = 1'b0;
        pick     = rr_r;
        scan_idx = 0;
        cand     = '0;
        hit      = 1'b0;
        for (int i = 1; i <= NumRequesters; i++) begin
            scan_idx = int'(rr_r) + i;
            scan_idx = (scan_idx >= NumRequesters) ? scan_idx - NumRequesters : scan_idx;
            cand     = GW'(scan_idx);
            hit      = ~found & req_valid[cand];
            pick     = hit ? cand : pick;
            found    = found | hit;
        end
    end

    // Request field mux for the winning client.
    always_comb begin
        sel_rw    = 1'b0;
        sel_dev   = 7'd0;
        sel_reg   = 8'd0;
        sel_wdata = 8'd0;
        for (int i = 0; i < NumRequesters; i++) begin
            sel_rw    = sel_rw | (req_rw[i] & (pick == GW'(i)));
            sel_dev   = sel_dev | (req_dev[7*i +: 7] & {7{pick == GW'(i)}});
            sel_reg   = sel_reg | (req_reg[8*i +: 8] & {8{pick == GW'(i)}});
            sel_wdata = sel_wdata | (req_wdata[8*i +: 8] & {8{pick == GW'(i)}});
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx       = state_r;
        rr_nx          = rr_r;
        grant_nx       = grant;
        cnt_nx         = cnt_r;
        txn_valid_nx   = txn_valid;
        txn_rw_nx      = txn_rw;
        txn_dev_nx     = txn_dev;
        txn_reg_nx     = txn_reg;
        txn_wdata_nx   = txn_wdata;
        txn_abort_nx   = 1'b0;
        req_done_nx    = '0;
        rsp_rdata_nx   = rsp_rdata;
        rsp_nack_nx    = rsp_nack;
        rsp_timeout_nx = rsp_timeout;
        case (state_r)
            IDLE: begin
                if (found) begin
                    state_nx     = ISSUE;
                    grant_nx     = pick;
                    txn_valid_nx = 1'b1;
                    txn_rw_nx    = sel_rw;
                    txn_dev_nx   = sel_dev;
                    txn_reg_nx   = sel_reg;
                    txn_wdata_nx = sel_wdata;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (txn_valid && txn_ready) begin
                    state_nx     = WAIT;
                    cnt_nx       = '0;
                    txn_valid_nx = 1'b0;
                end else begin
                    state_nx = ISSUE;
                end
            end
            WAIT: begin
                if (txn_done) begin
                    state_nx       = DONE;
                    req_done_nx    = {{(NumRequesters-1){1'b0}}, 1'b1} << grant;
                    rsp_rdata_nx   = txn_rw ? txn_rdata : 8'h00;
                    rsp_nack_nx    = txn_nack;
                    rsp_timeout_nx = 1'b0;
                end else if (cnt_r == CntLast) begin
                    state_nx       = DONE;
                    txn_abort_nx   = 1'b1;
                    req_done_nx    = {{(NumRequesters-1){1'b0}}, 1'b1} << grant;
                    rsp_rdata_nx   = 8'h00;
                    rsp_nack_nx    = 1'b0;
                    rsp_timeout_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_r + CW'(1);
                end
            end
            DONE: begin
                rr_nx    = grant;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_r        <= GW'(NumRequesters - 1);
            cnt_r       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            txn_valid   <= 1'b0;
            txn_rw      <= 1'b0;
            txn_dev     <= 7'd0;
            txn_reg     <= 8'd0;
            txn_wdata   <= 8'd0;
            txn_abort   <= 1'b0;
            req_done    <= '0;
            rsp_rdata   <= 8'd0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_r     <= state_nx;
            rr_r        <= rr_nx;
            cnt_r       <= cnt_nx;
            grant       <= grant_nx;
            busy        <= busy_nx;
            txn_valid   <= txn_valid_nx;
            txn_rw      <= txn_rw_nx;
            txn_dev     <= txn_dev_nx;
            txn_reg     <= txn_reg_nx;
            txn_wdata   <= txn_wdata_nx;
            txn_abort   <= txn_abort_nx;
            req_done    <= req_done_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_nack    <= rsp_nack_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: per-client request queues, a scripted
// master model and a round-robin reference model that predicts service order.
module tb_i2c_txn_arbiter;
    localparam int NR = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]   req_valid = '0, req_rw = '0;
    logic [7*NR-1:0] req_dev = '0;
    logic [8*NR-1:0] req_reg = '0, req_wdata = '0;
    logic [NR-1:0]   req_done;
    logic [7:0]      rsp_rdata;
    logic            rsp_nack, rsp_timeout, busy;
    logic [0:0]      grant;
    logic            txn_valid, txn_rw, txn_abort;
    logic            txn_ready = 1'b0, txn_done = 1'b0, txn_nack = 1'b0;
    logic [6:0]      txn_dev;
    logic [7:0]      txn_reg, txn_wdata;
    logic [7:0]      txn_rdata = 8'h00;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NumRequesters(NR), .TimeoutCycles(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .busy(busy), .grant(grant),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_rw(txn_rw),
        .txn_dev(txn_dev), .txn_reg(txn_reg), .txn_wdata(txn_wdata),
        .txn_done(txn_done), .txn_rdata(txn_rdata), .txn_nack(txn_nack),
        .txn_abort(txn_abort)
    );

    typedef struct { bit rw; bit [6:0] dev; bit [7:0] rg; bit [7:0] wd; } req_t;
    // kind: 0 = completes normally, 1 = never completes (timeout), 2 = hangs (reset test)
    typedef struct { int kind; int rdy; int dly; bit [7:0] rdata; bit nack; } beh_t;
    typedef struct { int client; bit [7:0] rdata; bit nack; bit tmo; } exp_t;

    req_t cq [NR][$];
    beh_t beh_q[$];
    exp_t exp_q[$];
    req_t txn_q[$];
    int   tests = 0, fails = 0;
    int   m_rr = NR - 1;
    int   abort_seen = 0, abort_exp = 0;
    bit   m_hang = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic present(input int i);
        if (cq[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_rw[i]           = cq[i][0].rw;
            req_dev[i*7 +: 7]   = cq[i][0].dev;
            req_reg[i*8 +: 8]   = cq[i][0].rg;
            req_wdata[i*8 +: 8] = cq[i][0].wd;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic add_req(input int i, input bit rw, input bit [6:0] dev, input bit [7:0] rg, input bit [7:0] wd);
        req_t r;
        r.rw = rw; r.dev = dev; r.rg = rg; r.wd = wd;
        cq[i].push_back(r);
    endtask

    task automatic add_beh(input int kind, input int rdy, input int dly, input bit [7:0] rdata, input bit nack);
        beh_t b;
        b.kind = kind; b.rdy = rdy; b.dly = dly; b.rdata = rdata; b.nack = nack;
        beh_q.push_back(b);
    endtask

    task automatic rand_beh();
        add_beh(($urandom % 10 == 0) ? 1 : 0, int'($urandom % 4), int'($urandom % 15),
                8'($urandom), ($urandom % 4) == 0);
    endtask

    // Reference model: serve every queued request, always picking the first
    // pending client after the last one served.
    task automatic plan();
        int n[NR];
        int total = 0;
        int k = 0;
        for (int i = 0; i < NR; i++) begin
            n[i] = cq[i].size();
            total += n[i];
        end
        while (total > 0) begin
            int   pc = -1;
            req_t r;
            beh_t b;
            exp_t e;
            for (int j = 1; j <= NR; j++) begin
                int c = (m_rr + j) % NR;
                if (pc < 0 && n[c] > 0) pc = c;
            end
            r = cq[pc][cq[pc].size() - n[pc]];
            n[pc]--;
            total--;
            b = beh_q[k];
            k++;
            txn_q.push_back(r);
            e.client = pc;
            e.tmo    = (b.kind == 1);
            e.nack   = e.tmo ? 1'b0 : b.nack;
            e.rdata  = (e.tmo || !r.rw) ? 8'h00 : b.rdata;
            exp_q.push_back(e);
            if (e.tmo) abort_exp++;
            m_rr = pc;
        end
    endtask

    task automatic run_round();
        int cyc = 0;
        plan();
        @(negedge clk);
        for (int i = 0; i < NR; i++) present(i);
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("round_complete", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_txn_valid", txn_valid, 0);
    endtask

    // Master model: accepts each transaction and replies per its scripted behaviour.
    initial begin
        beh_t b;
        req_t r;
        int   k;
        forever begin
            @(negedge clk);
            if (reset) begin
                txn_ready = 1'b0;
                txn_done  = 1'b0;
                continue;
            end
            if (!txn_valid) begin
                txn_done = (!m_hang && ($urandom % 8 == 0));
                txn_nack = 1'b1;
                txn_rdata = 8'($urandom);
                continue;
            end
            txn_done = 1'b0;
            chk("txn_expected", (beh_q.size() > 0 && txn_q.size() > 0), 1);
            b = '{0, 0, 0, 8'h00, 1'b0};
            if (beh_q.size() > 0) b = beh_q.pop_front();
            if (txn_q.size() > 0) begin
                r = txn_q.pop_front();
                chk("txn_rw", txn_rw, r.rw);
                chk("txn_dev", txn_dev, r.dev);
                chk("txn_reg", txn_reg, r.rg);
                chk("txn_wdata", txn_wdata, r.wd);
            end
            chk("busy_in_txn", busy, 1);
            repeat (b.rdy) @(negedge clk);
            txn_ready = 1'b1;
            @(negedge clk);
            txn_ready = 1'b0;
            chk("txn_valid_drop", txn_valid, 0);
            if (b.kind == 2) begin
                m_hang = 1'b1;
            end else if (b.kind == 1) begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!txn_abort && k < 64);
                chk("abort_latency", k, 15);
                txn_done = 1'b1;
                @(negedge clk);
                txn_done = 1'b0;
                chk("abort_width", txn_abort, 0);
            end else begin
                repeat (b.dly) @(negedge clk);
                txn_done  = 1'b1;
                txn_rdata = b.rdata;
                txn_nack  = b.nack;
                @(negedge clk);
                txn_done  = 1'b0;
                txn_rdata = 8'($urandom);
                txn_nack  = 1'($urandom);
            end
        end
    end

    // Scoreboard monitor: every req_done must match the next predicted completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (txn_abort) abort_seen++;
            if (!reset && req_done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req_done", req_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_done", req_done, 1 << e.client);
                    chk("grant", grant, e.client);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_nack", rsp_nack, e.nack);
                    chk("rsp_timeout", rsp_timeout, e.tmo);
                end
            end
        end
    end

    // Client model: advance to the next queued request on req_done; scramble
    // the granted client's inputs mid-transaction.
    initial begin
        int c;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_done[i]) begin
                        if (cq[i].size() > 0) void'(cq[i].pop_front());
                        present(i);
                    end
                end
                if (txn_valid && exp_q.size() > 0) begin
                    c = exp_q[0].client;
                    req_rw[c]           = 1'($urandom);
                    req_dev[c*7 +: 7]   = 7'($urandom);
                    req_reg[c*8 +: 8]   = 8'($urandom);
                    req_wdata[c*8 +: 8] = 8'($urandom);
                    if ($urandom % 3 == 0) req_valid[c] = 1'b0;
                end
            end
        end
    end

    initial begin
        int   cyc;
        req_t r;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txn_valid", txn_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_done", req_done, 0);
        chk("rst_grant", grant, 0);
        chk("rst_abort", txn_abort, 0);
        chk("rst_rsp", {rsp_rdata, rsp_nack, rsp_timeout}, 0);
        reset = 1'b0;
        @(negedge clk);

        add_req(0, 1'b0, 7'h55, 8'd135, 8'h40);
        add_beh(0, 3, 10, 8'hAA, 1'b0);
        run_round();

        add_req(1, 1'b1, 7'h1A, 8'd7, 8'h00);
        add_beh(0, 1, 5, 8'h01, 1'b0);
        run_round();

        for (int k = 0; k < 2; k++) begin
            add_req(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            add_req(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
        end
        repeat (4) add_beh(0, 0, 2, 8'($urandom), 1'b0);
        run_round();

        add_req(0, 1'b1, 7'h50, 8'h10, 8'h00);
        add_req(1, 1'b0, 7'h51, 8'h11, 8'h22);
        add_beh(0, 0, 4, 8'h77, 1'b1);
        add_beh(0, 2, 3, 8'h00, 1'b0);
        run_round();

        add_req(1, 1'b1, 7'h3C, 8'h20, 8'h00);
        add_req(0, 1'b1, 7'h3D, 8'h21, 8'h00);
        add_beh(1, 2, 0, 8'hEE, 1'b0);
        add_beh(0, 1, 14, 8'h5A, 1'b0);
        run_round();

        for (int rnd = 0; rnd < 25; rnd++) begin
            int n0 = int'($urandom % 4);
            int n1 = int'($urandom % 4);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) add_req(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            for (int k = 0; k < n1; k++) add_req(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            for (int k = 0; k < n0 + n1; k++) rand_beh();
            run_round();
        end

        add_req(1, 1'b0, 7'h2B, 8'h44, 8'h99);
        add_beh(2, 1, 0, 8'h00, 1'b0);
        r = cq[1][0];
        txn_q.push_back(r);
        @(negedge clk);
        present(1);
        cyc = 0;
        while (!m_hang && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reset_test_reached_wait", m_hang, 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_txn_valid", txn_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_abort", txn_abort, 0);
        chk("midrst_req_done", req_done, 0);
        for (int i = 0; i < NR; i++) cq[i].delete();
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("midrst_req_done_hold", req_done, 0);
        m_rr  = NR - 1;
        m_hang = 1'b0;
        reset = 1'b0;
        add_req(1, 1'b1, 7'h11, 8'h01, 8'h00);
        add_req(0, 1'b1, 7'h22, 8'h02, 8'h00);
        add_beh(0, 0, 3, 8'hC3, 1'b0);
        add_beh(0, 1, 2, 8'h3C, 1'b0);
        run_round();

        chk("abort_count", abort_seen, abort_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end
endmodule
